// File: rtl/spiflash_pkg.sv
// Shared definitions for the SPI flash clock generator: FSM state encoding,
// defaults and the registered output bundle.
package spiflash_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LEAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  localparam logic CPOL_DEFAULT = 1'b0;
  localparam int   LEAD_MAX     = 15;

  // Every externally visible output is carried in one registered bundle.
  typedef struct packed {
    logic busy;
    logic done;
    logic edge_lead;
    logic edge_trail;
    logic d0;
    logic d1;
    logic oe;
  } out_t;

endpackage

// File: rtl/spiflash_clkdiv.sv
// Half-period tick generator. tick is high in the last system-clock cycle of
// each DIV-cycle half period while enabled; constant 1 when DIV=0.
module spiflash_clkdiv #(
  parameter int DIV = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (DIV == 0) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{clock, reset, en, clr};
    assign tick = 1'b1;
  end else begin : g_div
    localparam int DW = $clog2(DIV + 1);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] cnt;

    // Count system clocks within the current half period; restart on clear.
    always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples pre-edge values regardless of statement order.
      if (reset || clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + DW'(1);
      end
    end

    assign tick = en && (cnt == LAST);
  end

endmodule

// File: rtl/spiflash_clkgen.sv
// SPI flash SCK burst generator driving a DDR output cell.
// Optional macro SPICLK_FREERUN_EN adds a 'hold' input that freezes the
// period countdown in RUN so SCK can run indefinitely.
module spiflash_clkgen
  import spiflash_pkg::*;
#(
  parameter int   CNT_W = 8,
  parameter int   DIV   = 0,
  parameter logic CPOL  = CPOL_DEFAULT,
  parameter int   LEAD  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
`ifdef SPICLK_FREERUN_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic             edge_lead,
  output logic             edge_trail,
  output logic             ddr_d0,
  output logic             ddr_d1,
  output logic             ddr_oe
);

  localparam bit FULL = (DIV == 0);
  localparam logic [3:0] LEAD_INIT = (LEAD > 0 && LEAD <= LEAD_MAX) ? 4'(LEAD - 1) : 4'd0;
  localparam out_t IDLE_OUT = '{busy: 1'b0, done: 1'b0, edge_lead: 1'b0,
                                edge_trail: 1'b0, d0: CPOL, d1: CPOL, oe: 1'b0};
  localparam logic [CNT_W-1:0] LAST_PERIOD = CNT_W'(1);

  logic [1:0]       st, st_n;
  logic [CNT_W-1:0] per_cnt, per_cnt_n;
  logic [3:0]       lead_cnt, lead_cnt_n;
  logic             level, level_n;
  logic             enter_run;
  logic             tick;
  logic             hold_i;
  out_t             out_q, out_n;

`ifdef SPICLK_FREERUN_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  spiflash_clkdiv #(.DIV(DIV)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .en    (st == ST_RUN),
    .clr   (st != ST_RUN),
    .tick  (tick)
  );

  // Next-state and next-output decode; outputs describe the coming cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    st_n       = st;
    per_cnt_n  = per_cnt;
    lead_cnt_n = lead_cnt;
    level_n    = level;
    enter_run  = 1'b0;
    out_n      = IDLE_OUT;

    case (st)
      ST_IDLE: begin
        if (start) begin
          if (count == '0) begin
            out_n.done = 1'b1;
          end else begin
            per_cnt_n = count;
            if (LEAD > 0) begin
              st_n       = ST_LEAD;
              lead_cnt_n = LEAD_INIT;
              out_n.busy = 1'b1;
              out_n.oe   = 1'b1;
            end else begin
              enter_run = 1'b1;
            end
          end
        end
      end

      ST_LEAD: begin
        out_n.busy = 1'b1;
        out_n.oe   = 1'b1;
        if (lead_cnt == 4'd0) enter_run = 1'b1;
        else                  lead_cnt_n = lead_cnt - 4'd1;
      end

      ST_RUN: begin
        out_n.busy = 1'b1;
        out_n.oe   = 1'b1;
        if (FULL) begin
          if (per_cnt == LAST_PERIOD && !hold_i) begin
            st_n             = ST_TAIL;
            out_n.edge_trail = 1'b1;
          end else begin
            if (!hold_i) per_cnt_n = per_cnt - LAST_PERIOD;
            out_n.d1         = ~CPOL;
            out_n.edge_lead  = 1'b1;
            out_n.edge_trail = 1'b1;
          end
        end else begin
          out_n.d0 = level;
          out_n.d1 = level;
          if (tick) begin
            if (level == CPOL) begin
              // Second half of a period ends: either finish or start next.
              if (per_cnt == LAST_PERIOD && !hold_i) begin
                st_n     = ST_TAIL;
                out_n.d0 = CPOL;
                out_n.d1 = CPOL;
              end else begin
                if (!hold_i) per_cnt_n = per_cnt - LAST_PERIOD;
                level_n         = ~CPOL;
                out_n.d0        = ~CPOL;
                out_n.d1        = ~CPOL;
                out_n.edge_lead = 1'b1;
              end
            end else begin
              level_n          = CPOL;
              out_n.d0         = CPOL;
              out_n.d1         = CPOL;
              out_n.edge_trail = 1'b1;
            end
          end
        end
      end

      default: begin  // ST_TAIL
        st_n       = ST_IDLE;
        out_n.done = 1'b1;
      end
    endcase

    // First RUN cycle always carries a leading edge at the new level.
    if (enter_run) begin
      st_n            = ST_RUN;
      out_n.busy      = 1'b1;
      out_n.oe        = 1'b1;
      out_n.edge_lead = 1'b1;
      if (FULL) begin
        out_n.d1 = ~CPOL;
      end else begin
        level_n  = ~CPOL;
        out_n.d0 = ~CPOL;
        out_n.d1 = ~CPOL;
      end
    end
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= ST_IDLE;
      per_cnt  <= '0;
      lead_cnt <= 4'd0;
      level    <= CPOL;
      out_q    <= IDLE_OUT;
    end else begin
      st       <= st_n;
      per_cnt  <= per_cnt_n;
      lead_cnt <= lead_cnt_n;
      level    <= level_n;
      out_q    <= out_n;
    end
  end

  assign busy       = out_q.busy;
  assign done       = out_q.done;
  assign edge_lead  = out_q.edge_lead;
  assign edge_trail = out_q.edge_trail;
  assign ddr_d0     = out_q.d0;
  assign ddr_d1     = out_q.d1;
  assign ddr_oe     = out_q.oe;

endmodule

// File: tb/tb_spiflash_clkgen.sv
// Self-checking bench for spiflash_clkgen: a full-rate instance
// (DIV=0, CPOL=0, LEAD=1) and a divided instance (DIV=2, CPOL=1, LEAD=0).
module tb_spiflash_clkgen;

  logic clock;
  logic reset;

  logic       f_start, d_start;
  logic [7:0] f_count, d_count;
  logic f_busy, f_done, f_lead, f_trail, f_d0, f_d1, f_oe;
  logic d_busy, d_done, d_lead, d_trail, d_d0, d_d1, d_oe;
`ifdef SPICLK_FREERUN_EN
  logic f_hold;
  logic d_hold;
`endif

  logic [6:0] f_out, d_out;
  assign f_out = {f_busy, f_done, f_lead, f_trail, f_d0, f_d1, f_oe};
  assign d_out = {d_busy, d_done, d_lead, d_trail, d_d0, d_d1, d_oe};

  spiflash_clkgen #(.CNT_W(8), .DIV(0), .CPOL(1'b0), .LEAD(1)) u_full (
    .clock(clock), .reset(reset), .start(f_start), .count(f_count),
`ifdef SPICLK_FREERUN_EN
    .hold(f_hold),
`endif
    .busy(f_busy), .done(f_done), .edge_lead(f_lead), .edge_trail(f_trail),
    .ddr_d0(f_d0), .ddr_d1(f_d1), .ddr_oe(f_oe)
  );

  spiflash_clkgen #(.CNT_W(8), .DIV(2), .CPOL(1'b1), .LEAD(0)) u_div (
    .clock(clock), .reset(reset), .start(d_start), .count(d_count),
`ifdef SPICLK_FREERUN_EN
    .hold(d_hold),
`endif
    .busy(d_busy), .done(d_done), .edge_lead(d_lead), .edge_trail(d_trail),
    .ddr_d0(d_d0), .ddr_d1(d_d1), .ddr_oe(d_oe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Output bundle order: busy done lead trail d0 d1 oe
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_LEAD = 7'b1000001;
  localparam logic [6:0] O_RUN1 = 7'b1010011;
  localparam logic [6:0] O_RUNN = 7'b1011011;
  localparam logic [6:0] O_TAIL = 7'b1001001;
  localparam logic [6:0] O_DONE = 7'b0100000;
  localparam logic [6:0] O_DIV_IDLE = 7'b0000110;

  typedef struct {
    logic       start;
    logic [7:0] count;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int edges, dones, done_at, toggles, trails;
    logic prev_d;
    logic exp_lvl;
    bit   saw_done;

    vecs[0]  = '{1'b1, 8'd4,   O_LEAD};
    vecs[1]  = '{1'b0, 8'd4,   O_RUN1};
    vecs[2]  = '{1'b0, 8'd4,   O_RUNN};
    vecs[3]  = '{1'b0, 8'd4,   O_RUNN};
    vecs[4]  = '{1'b0, 8'd4,   O_RUNN};
    vecs[5]  = '{1'b0, 8'd4,   O_TAIL};
    vecs[6]  = '{1'b0, 8'd4,   O_DONE};
    vecs[7]  = '{1'b1, 8'd0,   O_DONE};   // start with count=0 in the done cycle
    vecs[8]  = '{1'b0, 8'd0,   O_IDLE};
    vecs[9]  = '{1'b1, 8'd1,   O_LEAD};
    vecs[10] = '{1'b1, 8'd200, O_RUN1};   // start while busy is ignored
    vecs[11] = '{1'b1, 8'd200, O_TAIL};
    vecs[12] = '{1'b0, 8'd0,   O_DONE};
    vecs[13] = '{1'b0, 8'd0,   O_IDLE};

    reset = 1'b1;
    f_start = 1'b0; f_count = 8'd0;
    d_start = 1'b0; d_count = 8'd0;
`ifdef SPICLK_FREERUN_EN
    f_hold = 1'b0; d_hold = 1'b0;
`endif
    repeat (3) step();
    check("reset_full", 32'(f_out), 32'(O_IDLE));
    check("reset_div", 32'(d_out), 32'(O_DIV_IDLE));
    reset = 1'b0;
    step();

    // Full-rate cycle-by-cycle table.
    for (int i = 0; i < 14; i++) begin
      f_start = vecs[i].start;
      f_count = vecs[i].count;
      step();
      check($sformatf("vec%0d", i), 32'(f_out), 32'(vecs[i].exp));
    end
    f_start = 1'b0;

    // Divided mode, count=3: levels 0,0,1,1 repeating, TAIL at CPOL.
    d_start = 1'b1; d_count = 8'd3;
    edges = 0; trails = 0; toggles = 0; done_at = 0; prev_d = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      d_start = 1'b0;
      if (d_lead)  edges++;
      if (d_trail) trails++;
      if (d_d0 != prev_d) toggles++;
      prev_d = d_d0;
      if (d_done && done_at == 0) done_at = k;
      if (k <= 13) begin
        exp_lvl = (k == 13) ? 1'b1 : ((((k - 1) / 2) % 2) == 1);
        check($sformatf("div_lvl%0d", k), 32'({d_d0, d_d1, d_oe}), 32'({exp_lvl, exp_lvl, 1'b1}));
      end
    end
    check("div_lead_cnt", 32'(edges), 32'd3);
    check("div_trail_cnt", 32'(trails), 32'd3);
    check("div_toggles", 32'(toggles), 32'd6);
    check("div_done_at", 32'(done_at), 32'd14);
    check("div_idle_after", 32'(d_out), 32'(O_DIV_IDLE));

    // Reset during RUN of a count=8 burst.
    f_start = 1'b1; f_count = 8'd8;
    step();
    f_start = 1'b0;
    repeat (3) step();
    check("mid_run_busy", 32'(f_out), 32'(O_RUNN));
    reset = 1'b1;
    step();
    check("rst_mid_full", 32'(f_out), 32'(O_IDLE));
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (f_done || f_busy || f_oe) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);

    // Start held high through a count=2 burst: exactly one follow-on burst.
    f_start = 1'b1; f_count = 8'd2;
    edges = 0; dones = 0; saw_done = 1'b0;
    for (int c = 0; c < 40 && dones < 2; c++) begin
      step();
      if (saw_done) begin
        check("overlap_restart", 32'({f_busy, f_oe}), 32'b11);
        f_start = 1'b0;
        saw_done = 1'b0;
      end
      if (f_lead) edges++;
      if (f_done) begin
        dones++;
        saw_done = (dones == 1);
      end
    end
    f_start = 1'b0;
    check("overlap_dones", 32'(dones), 32'd2);
    check("overlap_edges", 32'(edges), 32'd4);
    repeat (3) step();
    check("overlap_idle", 32'(f_out), 32'(O_IDLE));

    // Maximum count completes without wrap: done at start+258.
    f_start = 1'b1; f_count = 8'd255;
    edges = 0; done_at = 0;
    for (int k = 1; k <= 300 && done_at == 0; k++) begin
      step();
      f_start = 1'b0;
      if (f_lead) edges++;
      if (f_done) done_at = k;
    end
    check("max_edges", 32'(edges), 32'd255);
    check("max_done_at", 32'(done_at), 32'd258);

`ifdef SPICLK_FREERUN_EN
    // hold=1 for the first 10 RUN cycles of a count=2 burst: 12 edges.
    f_hold = 1'b1;
    f_start = 1'b1; f_count = 8'd2;
    edges = 0; done_at = 0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      step();
      f_start = 1'b0;
      if (f_lead) edges++;
      if (edges == 11) f_hold = 1'b0;
      if (f_done) done_at = k;
    end
    f_hold = 1'b0;
    check("hold_edges", 32'(edges), 32'd12);
    check("hold_done_seen", 32'(done_at != 0), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
